// File: rtl/dcache_plru_pkg.sv
// Shared dcache sizing and types for the pseudo-LRU replacement state.
// Tree layout per set: b0 root, b1/b2 half nodes, b3..b6 pair nodes.
package dcache_plru_pkg;

    localparam int DCACHE_SETS  = 64;
    localparam int DCACHE_WAYS  = 8;
    localparam int DCACHE_IDX_W = 6;
    localparam int DCACHE_WAY_W = 3;
    localparam int PLRU_BITS    = 7;

    typedef logic [DCACHE_IDX_W-1:0] idx_t;
    typedef logic [DCACHE_WAY_W-1:0] way_t;
    typedef logic [PLRU_BITS-1:0]    plru_t;

endpackage

// File: rtl/dcache_plru_if.sv
// Replacement-unit and ctrl connections to the PLRU state store.
// The master modport is the requesting side; the slave is dcache_plru.
interface dcache_plru_if;
    import dcache_plru_pkg::*;

    logic replace2plru_valid;
    idx_t replace2plru_index;
    way_t plru2replace_way;
    logic replace2plru_ready;
    logic ctrl2plru_hit_valid;
    idx_t ctrl2plru_hit_index;
    way_t ctrl2plru_hit_way;
    logic plru2ctrl_busy;

    modport master (
        output replace2plru_valid,
        output replace2plru_index,
        input  plru2replace_way,
        output replace2plru_ready,
        output ctrl2plru_hit_valid,
        output ctrl2plru_hit_index,
        output ctrl2plru_hit_way,
        input  plru2ctrl_busy
    );

    modport slave (
        input  replace2plru_valid,
        input  replace2plru_index,
        output plru2replace_way,
        input  replace2plru_ready,
        input  ctrl2plru_hit_valid,
        input  ctrl2plru_hit_index,
        input  ctrl2plru_hit_way,
        output plru2ctrl_busy
    );

endinterface

// File: rtl/dcache_plru_tree8.sv
// Combinational 8-way tree PLRU: victim walk and MRU touch of one set.
// A node value of 0 points at the lower half, 1 at the upper half.
module dcache_plru_tree8
    import dcache_plru_pkg::*;
(
    input  plru_t i_bits,
    input  way_t  i_way,
    output way_t  o_victim,
    output plru_t o_bits
);

    logic w_v2;
    logic w_v1;
    logic w_v0;

    always_comb begin
        w_v2 = i_bits[0];
        w_v1 = w_v2 ? i_bits[2] : i_bits[1];
        w_v0 = 1'b0;
        unique case ({w_v2, w_v1})
            2'b00:   w_v0 = i_bits[3];
            2'b01:   w_v0 = i_bits[4];
            2'b10:   w_v0 = i_bits[5];
            default: w_v0 = i_bits[6];
        endcase
    end

    assign o_victim = {w_v2, w_v1, w_v0};

    // Point every node on the path away from the touched way.
    always_comb begin
        o_bits    = i_bits;
        o_bits[0] = ~i_way[2];
        if (i_way[2]) o_bits[2] = ~i_way[1];
        else          o_bits[1] = ~i_way[1];
        unique case (i_way[2:1])
            2'b00:   o_bits[3] = ~i_way[0];
            2'b01:   o_bits[4] = ~i_way[0];
            2'b10:   o_bits[5] = ~i_way[0];
            default: o_bits[6] = ~i_way[0];
        endcase
    end

endmodule

// File: rtl/dcache_plru.sv
// Per-set tree pseudo-LRU store: registered victim lookup, fill commit
// and hit touch; a same-index hit is chained after the commit touch.
module dcache_plru
    import dcache_plru_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    dcache_plru_if.slave bus
);

    plru_t r_bits [DCACHE_SETS];
    way_t  r_way;
    idx_t  r_idx;
    logic  r_busy;

    logic  w_commit;
    plru_t w_look;
    plru_t w_cmt_in;
    plru_t w_cmt_out;
    plru_t w_hit_in;
    plru_t w_hit_out;
    way_t  w_victim;
    plru_t w_unused_bits;
    way_t  w_unused_v0;
    way_t  w_unused_v1;
    logic  w_unused;

    assign w_commit = bus.replace2plru_ready & r_busy;
    assign w_look   = r_bits[bus.replace2plru_index];
    assign w_cmt_in = r_bits[r_idx];

    always_comb begin
        w_hit_in = r_bits[bus.ctrl2plru_hit_index];
        if (w_commit && (bus.ctrl2plru_hit_index == r_idx))
            w_hit_in = w_cmt_out;
    end

    dcache_plru_tree8 u_look (
        .i_bits   (w_look),
        .i_way    (3'd0),
        .o_victim (w_victim),
        .o_bits   (w_unused_bits)
    );

    dcache_plru_tree8 u_commit (
        .i_bits   (w_cmt_in),
        .i_way    (r_way),
        .o_victim (w_unused_v0),
        .o_bits   (w_cmt_out)
    );

    dcache_plru_tree8 u_hit (
        .i_bits   (w_hit_in),
        .i_way    (bus.ctrl2plru_hit_way),
        .o_victim (w_unused_v1),
        .o_bits   (w_hit_out)
    );

    assign w_unused = ^{w_unused_bits, w_unused_v0, w_unused_v1};

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int s = 0; s < DCACHE_SETS; s++) r_bits[s] <= '0;
            r_way  <= '0;
            r_idx  <= '0;
            r_busy <= 1'b0;
        end else begin
            if (bus.replace2plru_valid) begin
                r_way <= w_victim;
                r_idx <= bus.replace2plru_index;
            end
            if (bus.replace2plru_valid) r_busy <= 1'b1;
            else if (w_commit)          r_busy <= 1'b0;
            if (w_commit) r_bits[r_idx] <= w_cmt_out;
            // Later write wins, and it already includes any same-set commit.
            if (bus.ctrl2plru_hit_valid)
                r_bits[bus.ctrl2plru_hit_index] <= w_hit_out;
        end
    end

    assign bus.plru2replace_way = r_way;
    assign bus.plru2ctrl_busy   = r_busy;

endmodule

// File: tb/tb_dcache_plru.sv
// Bench for dcache_plru: directed scenarios plus randomized traffic
// against a heap-indexed binary-tree model of each set.
module tb_dcache_plru;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    dcache_plru_if bus ();

    dcache_plru dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Model: tree nodes in heap order, children of node n are 2n+1, 2n+2.
    bit m_tree [64][7];
    int m_way;
    int m_busy;
    int m_idx;

    function automatic int m_victim(int s);
        int n = 0;
        int w = 0;
        for (int l = 0; l < 3; l++) begin
            int d = int'(m_tree[s][n]);
            w = w * 2 + d;
            n = 2 * n + 1 + d;
        end
        return w;
    endfunction

    task automatic m_touch(int s, int w);
        int n = 0;
        for (int l = 0; l < 3; l++) begin
            int d = (w >> (2 - l)) & 1;
            m_tree[s][n] = (d == 0);
            n = 2 * n + 1 + d;
        end
    endtask

    task automatic idle();
        bus.replace2plru_valid  = 1'b0;
        bus.replace2plru_index  = '0;
        bus.replace2plru_ready  = 1'b0;
        bus.ctrl2plru_hit_valid = 1'b0;
        bus.ctrl2plru_hit_index = '0;
        bus.ctrl2plru_hit_way   = '0;
    endtask

    // Update the model from the driven inputs, then cross one clock edge.
    task automatic step();
        int  nv;
        bit  cm;
        if (reset) begin
            for (int s = 0; s < 64; s++)
                for (int b = 0; b < 7; b++) m_tree[s][b] = 1'b0;
            m_way = 0; m_busy = 0; m_idx = 0;
        end else begin
            nv = bus.replace2plru_valid ?
                 m_victim(int'(bus.replace2plru_index)) : m_way;
            cm = bus.replace2plru_ready && (m_busy != 0);
            if (cm) m_touch(m_idx, m_way);
            if (bus.ctrl2plru_hit_valid)
                m_touch(int'(bus.ctrl2plru_hit_index),
                        int'(bus.ctrl2plru_hit_way));
            if (bus.replace2plru_valid) begin
                m_busy = 1;
                m_idx  = int'(bus.replace2plru_index);
            end else if (cm) begin
                m_busy = 0;
            end
            m_way = nv;
        end
        @(posedge clock);
        #1;
        idle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic lookup(int idx);
        bus.replace2plru_valid = 1'b1;
        bus.replace2plru_index = 6'(idx);
        step();
    endtask

    task automatic hit(int idx, int way);
        bus.ctrl2plru_hit_valid = 1'b1;
        bus.ctrl2plru_hit_index = 6'(idx);
        bus.ctrl2plru_hit_way   = 3'(way);
        step();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.plru2replace_way !== 3'd0 || bus.plru2ctrl_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset: way=%0d busy=%0b want way=0 busy=0",
                     bus.plru2replace_way, bus.plru2ctrl_busy);
        end
    endtask

    task automatic test_commit();
        do_reset();
        lookup(5);
        checks++;
        if (bus.plru2replace_way !== 3'd0 || bus.plru2ctrl_busy !== 1'b1) begin
            errors++;
            $display("FAIL lookup5: way=%0d busy=%0b want way=0 busy=1",
                     bus.plru2replace_way, bus.plru2ctrl_busy);
        end
        bus.replace2plru_ready = 1'b1;
        step();
        checks++;
        if (bus.plru2ctrl_busy !== 1'b0) begin
            errors++;
            $display("FAIL commit_busy: busy=%0b want 0", bus.plru2ctrl_busy);
        end
        lookup(5);
        checks++;
        if (bus.plru2replace_way !== 3'd4) begin
            errors++;
            $display("FAIL commit_relook: way=%0d want 4", bus.plru2replace_way);
        end
    endtask

    task automatic test_hit_seq();
        int seq [4] = '{0, 4, 2, 6};
        do_reset();
        foreach (seq[i]) hit(9, seq[i]);
        lookup(9);
        checks++;
        if (bus.plru2replace_way !== 3'd1) begin
            errors++;
            $display("FAIL hitseq9: way=%0d want 1", bus.plru2replace_way);
        end
        lookup(8);
        checks++;
        if (bus.plru2replace_way !== 3'd0) begin
            errors++;
            $display("FAIL hitseq_other: way=%0d want 0", bus.plru2replace_way);
        end
    endtask

    task automatic test_top_index();
        do_reset();
        for (int w = 0; w < 8; w++) hit(63, w);
        lookup(63);
        checks++;
        if (bus.plru2replace_way !== 3'd0) begin
            errors++;
            $display("FAIL top63: way=%0d want 0", bus.plru2replace_way);
        end
        hit(63, 0);
        lookup(0);
        checks++;
        if (bus.plru2replace_way !== 3'd0) begin
            errors++;
            $display("FAIL top_alias0: way=%0d want 0", bus.plru2replace_way);
        end
        lookup(63);
        checks++;
        if (bus.plru2replace_way !== 3'd4) begin
            errors++;
            $display("FAIL top63_touch: way=%0d want 4", bus.plru2replace_way);
        end
    endtask

    task automatic test_rbw();
        do_reset();
        bus.ctrl2plru_hit_valid = 1'b1;
        bus.ctrl2plru_hit_index = 6'd3;
        bus.ctrl2plru_hit_way   = 3'd0;
        lookup(3);
        checks++;
        if (bus.plru2replace_way !== 3'd0) begin
            errors++;
            $display("FAIL rbw_pre: way=%0d want 0", bus.plru2replace_way);
        end
        lookup(3);
        checks++;
        if (bus.plru2replace_way !== 3'd4) begin
            errors++;
            $display("FAIL rbw_post: way=%0d want 4", bus.plru2replace_way);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        lookup(7);
        bus.replace2plru_ready = 1'b1;
        hit(7, 1);
        lookup(7);
        checks++;
        if (bus.plru2replace_way !== 3'd4) begin
            errors++;
            $display("FAIL same_idx: way=%0d want 4", bus.plru2replace_way);
        end
        // Commit on set 7 and hit on set 11 together: both must land.
        bus.replace2plru_ready = 1'b1;
        hit(11, 0);
        lookup(7);
        checks++;
        if (bus.plru2replace_way !== 3'(m_way)) begin
            errors++;
            $display("FAIL diff_idx7: way=%0d want %0d",
                     bus.plru2replace_way, m_way);
        end
        lookup(11);
        checks++;
        if (bus.plru2replace_way !== 3'd4) begin
            errors++;
            $display("FAIL diff_idx11: way=%0d want 4", bus.plru2replace_way);
        end
    endtask

    task automatic test_reset_pending();
        int bad = 0;
        do_reset();
        for (int i = 0; i < 10; i++) hit($urandom_range(63), $urandom_range(7));
        lookup(2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (bus.plru2replace_way !== 3'd0 || bus.plru2ctrl_busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_pend: way=%0d busy=%0b want way=0 busy=0",
                     bus.plru2replace_way, bus.plru2ctrl_busy);
        end
        bus.replace2plru_ready = 1'b1;
        step();
        checks++;
        if (bus.plru2ctrl_busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_ready: busy=%0b want 0", bus.plru2ctrl_busy);
        end
        for (int s = 0; s < 64; s++) begin
            lookup(s);
            if (bus.plru2replace_way !== 3'd0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rst_sets: nonzero victims=%0d want 0", bad);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            bus.replace2plru_valid  = ($urandom_range(2) == 0);
            bus.replace2plru_index  = 6'($urandom_range(7));
            bus.replace2plru_ready  = ($urandom_range(1) == 0);
            bus.ctrl2plru_hit_valid = ($urandom_range(1) == 0);
            bus.ctrl2plru_hit_index = 6'($urandom_range(7));
            bus.ctrl2plru_hit_way   = 3'($urandom_range(7));
            reset = ($urandom_range(199) == 0);
            step();
            reset = 1'b0;
            checks++;
            if (bus.plru2replace_way !== 3'(m_way) ||
                bus.plru2ctrl_busy !== 1'(m_busy)) begin
                errors++;
                $display("FAIL rand c=%0d: way=%0d busy=%0b want way=%0d busy=%0d",
                         c, bus.plru2replace_way, bus.plru2ctrl_busy,
                         m_way, m_busy);
            end
        end
    endtask

    initial begin
        idle();
        m_way = 0; m_busy = 0; m_idx = 0;
        @(negedge clock);
        test_reset();
        test_commit();
        test_hit_seq();
        test_top_index();
        test_rbw();
        test_same_cycle();
        test_reset_pending();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
